// File: rtl/alarm_unit_12h_if.sv
// Bus between the 12-hour time counter / user controls and the alarm unit.
// master drives time, strobes and settings; slave is the alarm unit itself.
interface alarm_unit_12h_if;
  // Time counter side
  logic       ena;
  logic       pm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  // Programming and control
  logic       set_en;
  logic       set_pm;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       arm;
  logic       snooze;
  logic       stop;
  // Status
  logic       ringing;
  logic       snoozing;
  logic       set_err;
  logic       alarm_pm;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;

  modport master (
    output ena, pm, hh, mm, ss,
    output set_en, set_pm, set_hh, set_mm, arm, snooze, stop,
    input  ringing, snoozing, set_err, alarm_pm, alarm_hh, alarm_mm
  );

  modport slave (
    input  ena, pm, hh, mm, ss,
    input  set_en, set_pm, set_hh, set_mm, arm, snooze, stop,
    output ringing, snoozing, set_err, alarm_pm, alarm_hh, alarm_mm
  );
endinterface

// File: rtl/alarm_unit_12h.sv
// Alarm controller for a 12-hour BCD clock: programmable alarm, edge-detected
// minute match, ring with auto-off after RING_SECS ticks, and BCD snooze.
module alarm_unit_12h #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 9
) (
  input logic             clk,
  input logic             reset,
  alarm_unit_12h_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  localparam logic [7:0] RingLast  = 8'(RING_SECS - 1);
  localparam logic [7:0] SnoozeMin = 8'(SNOOZE_MIN);

  state_e     state_q;
  logic       prog_pm_q;
  logic [7:0] prog_hh_q;
  logic [7:0] prog_mm_q;
  logic       snz_pm_q;
  logic [7:0] snz_hh_q;
  logic [7:0] snz_mm_q;
  logic [7:0] cnt_q;
  logic       match_d_q;
  logic       ringing_q;
  logic       snoozing_q;
  logic       set_err_q;
  logic       alarm_pm_q;
  logic [7:0] alarm_hh_q;
  logic [7:0] alarm_mm_q;

  // Active target: snooze target while snoozing, programmed alarm otherwise
  logic       tgt_pm;
  logic [7:0] tgt_hh;
  logic [7:0] tgt_mm;
  always_comb begin
    if (state_q == StSnooze) begin
      tgt_pm = snz_pm_q;
      tgt_hh = snz_hh_q;
      tgt_mm = snz_mm_q;
    end else begin
      tgt_pm = prog_pm_q;
      tgt_hh = prog_hh_q;
      tgt_mm = prog_mm_q;
    end
  end

  logic match;
  logic trig;
  assign match = (bus.pm == tgt_pm) && (bus.hh == tgt_hh) && (bus.mm == tgt_mm) &&
                 (bus.ss == 8'h00);
  // One trigger per matching minute; match_d resets high so reset-time match is ignored
  assign trig  = match & ~match_d_q & bus.arm;

  // Validate the BCD alarm presented with set_en
  logic hh_ok;
  logic mm_ok;
  logic set_ok;
  always_comb begin
    hh_ok  = ((bus.set_hh[7:4] == 4'd0) && (bus.set_hh[3:0] >= 4'd1) &&
              (bus.set_hh[3:0] <= 4'd9)) ||
             ((bus.set_hh[7:4] == 4'd1) && (bus.set_hh[3:0] <= 4'd2));
    mm_ok  = (bus.set_mm[7:4] <= 4'd5) && (bus.set_mm[3:0] <= 4'd9);
    set_ok = hh_ok && mm_ok;
  end

  // Snooze target: current time plus SnoozeMin minutes with 12-hour BCD wrap
  logic [7:0] min_bin;
  logic [7:0] min_sum;
  logic [7:0] min_wrap;
  logic       carry;
  logic       nxt_pm;
  logic [7:0] nxt_hh;
  logic [7:0] nxt_mm;
  always_comb begin
    min_bin  = ({4'd0, bus.mm[7:4]} * 8'd10) + {4'd0, bus.mm[3:0]};
    min_sum  = min_bin + SnoozeMin;
    carry    = (min_sum >= 8'd60);
    min_wrap = carry ? (min_sum - 8'd60) : min_sum;
    nxt_mm   = {4'(min_wrap / 8'd10), 4'(min_wrap % 8'd10)};
    nxt_pm   = bus.pm;
    nxt_hh   = bus.hh;
    if (carry) begin
      case (bus.hh)
        8'h11: begin
          nxt_hh = 8'h12;
          nxt_pm = ~bus.pm;
        end
        8'h12:   nxt_hh = 8'h01;
        default: begin
          if (bus.hh[3:0] == 4'd9) begin
            nxt_hh = {bus.hh[7:4] + 4'd1, 4'd0};
          end else begin
            nxt_hh = bus.hh + 8'd1;
          end
        end
      endcase
    end
  end

  // Alarm FSM with registered status and active-target outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      prog_pm_q  <= 1'b0;
      prog_hh_q  <= 8'h12;
      prog_mm_q  <= 8'h00;
      snz_pm_q   <= 1'b0;
      snz_hh_q   <= 8'h12;
      snz_mm_q   <= 8'h00;
      cnt_q      <= 8'd0;
      match_d_q  <= 1'b1;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      set_err_q  <= 1'b0;
      alarm_pm_q <= 1'b0;
      alarm_hh_q <= 8'h12;
      alarm_mm_q <= 8'h00;
    end else begin
      set_err_q <= 1'b0;
      match_d_q <= match;
      if (bus.set_en && set_ok) begin
        prog_pm_q  <= bus.set_pm;
        prog_hh_q  <= bus.set_hh;
        prog_mm_q  <= bus.set_mm;
        state_q    <= StIdle;
        ringing_q  <= 1'b0;
        snoozing_q <= 1'b0;
        alarm_pm_q <= bus.set_pm;
        alarm_hh_q <= bus.set_hh;
        alarm_mm_q <= bus.set_mm;
      end else begin
        if (bus.set_en) begin
          set_err_q <= 1'b1;
        end
        case (state_q)
          StIdle: begin
            if (trig) begin
              state_q   <= StRing;
              cnt_q     <= 8'd0;
              ringing_q <= 1'b1;
            end
          end
          StRing: begin
            if (bus.stop) begin
              state_q   <= StIdle;
              ringing_q <= 1'b0;
            end else if (bus.snooze) begin
              state_q    <= StSnooze;
              snz_pm_q   <= nxt_pm;
              snz_hh_q   <= nxt_hh;
              snz_mm_q   <= nxt_mm;
              ringing_q  <= 1'b0;
              snoozing_q <= 1'b1;
              alarm_pm_q <= nxt_pm;
              alarm_hh_q <= nxt_hh;
              alarm_mm_q <= nxt_mm;
            end else if (!bus.arm) begin
              state_q   <= StIdle;
              ringing_q <= 1'b0;
            end else if (bus.ena) begin
              if (cnt_q == RingLast) begin
                state_q   <= StIdle;
                ringing_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          StSnooze: begin
            if (bus.stop || !bus.arm) begin
              state_q    <= StIdle;
              snoozing_q <= 1'b0;
              alarm_pm_q <= prog_pm_q;
              alarm_hh_q <= prog_hh_q;
              alarm_mm_q <= prog_mm_q;
            end else if (trig) begin
              state_q    <= StRing;
              cnt_q      <= 8'd0;
              ringing_q  <= 1'b1;
              snoozing_q <= 1'b0;
              alarm_pm_q <= prog_pm_q;
              alarm_hh_q <= prog_hh_q;
              alarm_mm_q <= prog_mm_q;
            end
          end
          default: begin
            state_q    <= StIdle;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.set_err  = set_err_q;
  assign bus.alarm_pm = alarm_pm_q;
  assign bus.alarm_hh = alarm_hh_q;
  assign bus.alarm_mm = alarm_mm_q;

endmodule

// File: tb/tb_alarm_unit_12h.sv
// Directed bench for alarm_unit_12h: expected outputs are queued as each step is
// driven and compared after the following clock edge.
module tb_alarm_unit_12h;

  logic clk = 1'b0;
  logic reset;

  alarm_unit_12h_if bus ();

  alarm_unit_12h #(
    .RING_SECS (60),
    .SNOOZE_MIN(9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Time-counter model
  logic       t_pm;
  logic [7:0] t_hh;
  logic [7:0] t_mm;
  logic [7:0] t_ss;

  // Expected active target
  logic       a_pm;
  logic [7:0] a_hh;
  logic [7:0] a_mm;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  task automatic put_time();
    bus.pm = t_pm;
    bus.hh = t_hh;
    bus.mm = t_mm;
    bus.ss = t_ss;
  endtask

  task automatic set_t(input logic p, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s);
    t_pm = p;
    t_hh = h;
    t_mm = m;
    t_ss = s;
    put_time();
  endtask

  task automatic adv_time();
    if (t_ss == 8'h59) begin
      t_ss = 8'h00;
      if (t_mm == 8'h59) begin
        t_mm = 8'h00;
        if (t_hh == 8'h11) begin
          t_hh = 8'h12;
          t_pm = ~t_pm;
        end else if (t_hh == 8'h12) begin
          t_hh = 8'h01;
        end else begin
          t_hh = bcd_inc(t_hh);
        end
      end else begin
        t_mm = bcd_inc(t_mm);
      end
    end else begin
      t_ss = bcd_inc(t_ss);
    end
    put_time();
  endtask

  task automatic load(input logic p, input logic [7:0] h, input logic [7:0] m);
    bus.set_en = 1'b1;
    bus.set_pm = p;
    bus.set_hh = h;
    bus.set_mm = m;
  endtask

  // Queue the outputs expected after the next edge
  task automatic exp_o(input string tag, input logic r, input logic s, input logic e);
    exp_t x;
    x.tag = tag;
    x.exp = {r, s, e, a_pm, a_hh, a_mm};
    sb_q.push_back(x);
  endtask

  // One clock: sample after the edge, advance time on ena, drop strobes, score
  task automatic cyc();
    exp_t        x;
    logic [19:0] obs;
    logic        was_ena;
    was_ena = bus.ena;
    @(posedge clk);
    #1;
    obs = {bus.ringing, bus.snoozing, bus.set_err, bus.alarm_pm, bus.alarm_hh, bus.alarm_mm};
    if (was_ena) adv_time();
    bus.set_en = 1'b0;
    bus.snooze = 1'b0;
    bus.stop   = 1'b0;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      checks++;
      assert (obs === x.exp)
      else begin
        failures++;
        $error("FAIL %s observed={r,s,e,pm,hh,mm}=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    bus.ena    = 1'b0;
    bus.set_en = 1'b0;
    bus.set_pm = 1'b0;
    bus.set_hh = 8'h00;
    bus.set_mm = 8'h00;
    bus.arm    = 1'b0;
    bus.snooze = 1'b0;
    bus.stop   = 1'b0;
    set_t(1'b0, 8'h12, 8'h00, 8'h00);
    a_pm = 1'b0; a_hh = 8'h12; a_mm = 8'h00;

    // Reset state; a time matching at reset must not fire
    exp_o("reset", 0, 0, 0); cyc();
    reset   = 1'b0;
    bus.arm = 1'b1;
    exp_o("no_fire_at_reset", 0, 0, 0); cyc();
    exp_o("no_fire_at_reset2", 0, 0, 0); cyc();
    bus.snooze = 1'b1; bus.stop = 1'b1;
    exp_o("idle_ignores_strobes", 0, 0, 0); cyc();

    // Basic ring and auto-off at 12:01 AM
    load(1'b0, 8'h12, 8'h01); a_mm = 8'h01;
    exp_o("set_1201", 0, 0, 0); cyc();
    set_t(1'b0, 8'h12, 8'h00, 8'h58); bus.ena = 1'b1;
    exp_o("pre_58", 0, 0, 0); cyc();
    exp_o("pre_59", 0, 0, 0); cyc();
    exp_o("ring_rise", 1, 0, 0); cyc();
    for (int i = 1; i < 60; i++) begin
      exp_o("ring_hold", 1, 0, 0); cyc();
    end
    exp_o("auto_off", 0, 0, 0); cyc();
    repeat (3) begin
      exp_o("stay_idle", 0, 0, 0); cyc();
    end

    // Stop in the 5th ring cycle, then the same alarm 24 hours later
    set_t(1'b0, 8'h12, 8'h00, 8'h59);
    exp_o("stop_pre", 0, 0, 0); cyc();
    exp_o("stop_rise", 1, 0, 0); cyc();
    for (int i = 1; i < 5; i++) begin
      exp_o("stop_hold", 1, 0, 0); cyc();
    end
    bus.stop = 1'b1;
    exp_o("stop", 0, 0, 0); cyc();
    for (int i = 6; i < 60; i++) begin
      exp_o("no_retrigger", 0, 0, 0); cyc();
    end
    set_t(1'b0, 8'h12, 8'h00, 8'h59);
    exp_o("day_pre", 0, 0, 0); cyc();
    exp_o("ring_24h", 1, 0, 0); cyc();
    bus.stop = 1'b1;
    exp_o("stop_24h", 0, 0, 0); cyc();

    // Snooze across midnight: 11:55 PM + 9 min -> 12:04 AM
    bus.ena = 1'b0;
    load(1'b1, 8'h11, 8'h55); a_pm = 1'b1; a_hh = 8'h11; a_mm = 8'h55;
    exp_o("set_1155pm", 0, 0, 0); cyc();
    set_t(1'b1, 8'h11, 8'h54, 8'h59); bus.ena = 1'b1;
    exp_o("pm_pre", 0, 0, 0); cyc();
    exp_o("ring_1155pm", 1, 0, 0); cyc();
    bus.snooze = 1'b1; a_pm = 1'b0; a_hh = 8'h12; a_mm = 8'h04;
    exp_o("snooze_midnight", 0, 1, 0); cyc();
    set_t(1'b0, 8'h12, 8'h03, 8'h59);
    exp_o("snz_pre", 0, 1, 0); cyc();
    a_pm = 1'b1; a_hh = 8'h11; a_mm = 8'h55;
    exp_o("snz_ring", 1, 0, 0); cyc();
    bus.stop = 1'b1;
    exp_o("snz_stop", 0, 0, 0); cyc();

    // Snooze from 12:55 PM -> 01:04 PM (no pm toggle), stop while snoozing
    bus.ena = 1'b0;
    load(1'b1, 8'h12, 8'h55); a_pm = 1'b1; a_hh = 8'h12; a_mm = 8'h55;
    exp_o("set_1255pm", 0, 0, 0); cyc();
    set_t(1'b1, 8'h12, 8'h54, 8'h59); bus.ena = 1'b1;
    exp_o("pre_1255", 0, 0, 0); cyc();
    exp_o("ring_1255", 1, 0, 0); cyc();
    bus.snooze = 1'b1; a_hh = 8'h01; a_mm = 8'h04;
    exp_o("snooze_12to1", 0, 1, 0); cyc();
    bus.snooze = 1'b1;
    exp_o("snooze_in_snooze", 0, 1, 0); cyc();
    bus.stop = 1'b1; a_hh = 8'h12; a_mm = 8'h55;
    exp_o("stop_in_snooze", 0, 0, 0); cyc();

    // Invalid sets after reset
    bus.ena = 1'b0;
    reset = 1'b1; a_pm = 1'b0; a_hh = 8'h12; a_mm = 8'h00;
    exp_o("reset2", 0, 0, 0); cyc();
    reset = 1'b0;
    load(1'b0, 8'h13, 8'h00);
    exp_o("bad_hh13", 0, 0, 1); cyc();
    exp_o("err_clear1", 0, 0, 0); cyc();
    load(1'b0, 8'h01, 8'h5A);
    exp_o("bad_mm5a", 0, 0, 1); cyc();
    exp_o("err_clear2", 0, 0, 0); cyc();
    load(1'b1, 8'h00, 8'h30);
    exp_o("bad_hh00", 0, 0, 1); cyc();
    exp_o("err_clear3", 0, 0, 0); cyc();

    // Disarm across the match, then arm dropped during ring
    load(1'b0, 8'h12, 8'h01); a_mm = 8'h01;
    exp_o("set_1201b", 0, 0, 0); cyc();
    bus.arm = 1'b0;
    set_t(1'b0, 8'h12, 8'h00, 8'h59); bus.ena = 1'b1;
    exp_o("dis_pre", 0, 0, 0); cyc();
    exp_o("disarm_match", 0, 0, 0); cyc();
    exp_o("disarm_after", 0, 0, 0); cyc();
    bus.arm = 1'b1;
    exp_o("rearm_mid_minute", 0, 0, 0); cyc();
    set_t(1'b0, 8'h12, 8'h00, 8'h59);
    exp_o("arm_pre", 0, 0, 0); cyc();
    exp_o("arm_ring", 1, 0, 0); cyc();
    bus.arm = 1'b0;
    exp_o("arm_drop", 0, 0, 0); cyc();
    bus.arm = 1'b1;

    // Stop and snooze together
    set_t(1'b0, 8'h12, 8'h00, 8'h59);
    exp_o("col_pre", 0, 0, 0); cyc();
    exp_o("col_ring", 1, 0, 0); cyc();
    bus.stop = 1'b1; bus.snooze = 1'b1;
    exp_o("stop_and_snooze", 0, 0, 0); cyc();

    // Valid set with snooze in the same cycle
    set_t(1'b0, 8'h12, 8'h00, 8'h59);
    exp_o("col2_pre", 0, 0, 0); cyc();
    exp_o("col2_ring", 1, 0, 0); cyc();
    bus.snooze = 1'b1;
    load(1'b1, 8'h03, 8'h30); a_pm = 1'b1; a_hh = 8'h03; a_mm = 8'h30;
    exp_o("set_and_snooze", 0, 0, 0); cyc();

    // Reset during ring
    bus.ena = 1'b0;
    load(1'b0, 8'h12, 8'h01); a_pm = 1'b0; a_hh = 8'h12; a_mm = 8'h01;
    exp_o("set_1201c", 0, 0, 0); cyc();
    set_t(1'b0, 8'h12, 8'h00, 8'h59); bus.ena = 1'b1;
    exp_o("rst_pre", 0, 0, 0); cyc();
    exp_o("rst_ring", 1, 0, 0); cyc();
    reset = 1'b1; a_hh = 8'h12; a_mm = 8'h00;
    exp_o("reset_in_ring", 0, 0, 0); cyc();
    reset = 1'b0;
    exp_o("after_reset", 0, 0, 0); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
